// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared types and limits for the ATM session timer
//
// Purpose: state encoding for the session timer FSM and the width/limit of the
// seconds value handed to the binary-to-BCD converter.
package atm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } timer_state_t;

  // Width of the remaining-seconds bus.
  localparam int SECS_W = 6;

  // Largest value the two-digit BCD converter downstream accepts.
  localparam int SECS_MAX = 60;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - one-second prescaler for the session timer
//
// Purpose: counts clock cycles 0..CLK_HZ-1 while enabled and flags the last
// cycle of each second. Held at zero when disabled or cleared.
//
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   enable  in   count while high (session running)
//   clear   in   force the count back to zero this cycle, suppressing tick
//   tick    out  high on the cycle the count equals CLK_HZ-1 (combinational)
module tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  // A 1 Hz clock still needs a one-bit counter; it just never leaves zero.
  localparam int                 CNT_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(CLK_HZ - 1);

  if (CLK_HZ < 1) begin : g_chk_clk_hz
    $error("tick_gen: CLK_HZ must be at least 1");
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && !clear && (cnt_q == CNT_MAX);

endmodule

// File: rtl/session_timer.sv
// rtl/session_timer.sv - inactivity countdown timer for the ATM user session
//
// Purpose: counts whole seconds down from TIMEOUT_S to zero while a session is
// running, reloads on user activity, flags the warning window and pulses once
// when the session expires.
//
// Ports:
//   clk       in   system clock, all state changes on the rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   begin a session from IDLE or EXPIRED; acts as activity in RUN
//   activity  in   user keypress strobe, reloads the countdown in RUN
//   cancel    in   abort/complete the session, back to IDLE (highest priority)
//   secs      out  remaining seconds, 0..TIMEOUT_S (registered)
//   running   out  high while in RUN (registered)
//   warn      out  high while running and secs <= WARN_S (registered)
//   expired   out  one-cycle pulse on RUN->EXPIRED (registered)
//   sec_tick  out  one-cycle pulse with each decrement in RUN (registered)
module session_timer
  import atm_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TIMEOUT_S = 60,
  parameter int WARN_S    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              activity,
  input  logic              cancel,
  output logic [SECS_W-1:0] secs,
  output logic              running,
  output logic              warn,
  output logic              expired,
  output logic              sec_tick
);

  if (TIMEOUT_S < 1 || TIMEOUT_S > SECS_MAX) begin : g_chk_timeout
    $error("session_timer: TIMEOUT_S must be in 1..SECS_MAX");
  end
  if (WARN_S < 0 || WARN_S > TIMEOUT_S) begin : g_chk_warn
    $error("session_timer: WARN_S must be in 0..TIMEOUT_S");
  end

  localparam logic [SECS_W-1:0] TIMEOUT_V = SECS_W'(TIMEOUT_S);
  localparam logic [SECS_W-1:0] WARN_V    = SECS_W'(WARN_S);

  timer_state_t      state_q, state_d;
  logic [SECS_W-1:0] secs_q, secs_d;
  logic              running_q, running_d;
  logic              warn_q, warn_d;
  logic              expired_q, expired_d;
  logic              sec_tick_q, sec_tick_d;

  logic              in_run;
  logic              reload;
  logic              tick;

  assign in_run = (state_q == RUN);
  // In RUN a start is just another keypress.
  assign reload = start || activity;

  // Reload and cancel restart the second boundary, so they clear the
  // prescaler and mask the tick in the same cycle.
  tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (in_run),
    .clear  (cancel || reload),
    .tick   (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      secs_q  <= '0;
    end else begin
      state_q <= state_d;
      secs_q  <= secs_d;
    end
  end

  // Next-state and seconds logic; priority cancel > start/activity > tick.
  always_comb begin
    state_d = state_q;
    secs_d  = secs_q;
    if (cancel) begin
      state_d = IDLE;
      secs_d  = '0;
    end else begin
      unique case (state_q)
        IDLE, EXPIRED: begin
          secs_d = '0;
          if (start) begin
            state_d = RUN;
            secs_d  = TIMEOUT_V;
          end
        end
        RUN: begin
          if (reload) begin
            secs_d = TIMEOUT_V;
          end else if (tick) begin
            // secs <= 1 rather than == 1 keeps the decrement from ever
            // wrapping even if secs were somehow zero in RUN.
            if (secs_q <= SECS_W'(1)) begin
              state_d = EXPIRED;
              secs_d  = '0;
            end else begin
              secs_d = secs_q - SECS_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          secs_d  = '0;
        end
      endcase
    end
  end

  // Output logic; values are computed from the next state so that the
  // registered outputs line up with the secs update.
  always_comb begin
    running_d  = (state_d == RUN);
    warn_d     = running_d && (secs_d <= WARN_V);
    sec_tick_d = in_run && tick;
    expired_d  = in_run && tick && (state_d == EXPIRED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q  <= 1'b0;
      warn_q     <= 1'b0;
      expired_q  <= 1'b0;
      sec_tick_q <= 1'b0;
    end else begin
      running_q  <= running_d;
      warn_q     <= warn_d;
      expired_q  <= expired_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  assign secs     = secs_q;
  assign running  = running_q;
  assign warn     = warn_q;
  assign expired  = expired_q;
  assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_session_timer.sv
// tb/tb_session_timer.sv - directed self-checking bench for session_timer
module tb_session_timer;

  localparam int CLK_HZ    = 4;
  localparam int TIMEOUT_S = 5;
  localparam int WARN_S    = 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       activity;
  logic       cancel;
  logic [5:0] secs;
  logic       running;
  logic       warn;
  logic       expired;
  logic       sec_tick;

  int tests_run;
  int tests_failed;
  int exp_seen;

  session_timer #(
    .CLK_HZ    (CLK_HZ),
    .TIMEOUT_S (TIMEOUT_S),
    .WARN_S    (WARN_S)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .activity (activity),
    .cancel   (cancel),
    .secs     (secs),
    .running  (running),
    .warn     (warn),
    .expired  (expired),
    .sec_tick (sec_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts expired pulses as seen at each falling edge.
  initial exp_seen = 0;
  always @(negedge clk) begin
    if (expired === 1'b1) exp_seen = exp_seen + 1;
  end

  // Advance to the next falling edge: inputs set before this were sampled
  // by the rising edge in between, and outputs are stable here.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic go_idle();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
  endtask

  // Leaves the bench just after the rising edge that sampled start (E0).
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    int seen0;
    int bad;
    rst_n = 1'b0;
    step(2);
    tests_run++;
    if ({secs, running, warn, expired, sec_tick} !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_values: got secs=%0d run=%b warn=%b exp=%b tick=%b, want all 0",
               secs, running, warn, expired, sec_tick);
    end
    rst_n = 1'b1;
    seen0 = exp_seen;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if ({secs, running, warn, expired, sec_tick} !== 10'd0) bad++;
    end
    tests_run++;
    if (bad != 0 || exp_seen != seen0) begin
      tests_failed++;
      $display("FAIL idle_50_cycles: got %0d nonzero cycles, %0d expiries, want 0 and 0",
               bad, exp_seen - seen0);
    end
  endtask

  task automatic test_full_expiry();
    int seen0;
    logic [5:0] e_secs;
    logic e_run, e_warn, e_exp, e_tick;
    go_idle();
    seen0 = exp_seen;
    pulse_start();
    for (int k = 0; k <= 22; k++) begin
      if (k > 0) step();
      // Now just after rising edge E_k, counted from the edge that sampled start.
      e_secs = (k < 20) ? 6'(5 - k / 4) : 6'd0;
      e_run  = (k < 20);
      e_warn = e_run && (e_secs <= 6'd2);
      e_exp  = (k == 20);
      e_tick = (k > 0) && (k % 4 == 0) && (k <= 20);
      tests_run++;
      if ({secs, running, warn, expired, sec_tick} !== {e_secs, e_run, e_warn, e_exp, e_tick}) begin
        tests_failed++;
        $display("FAIL expiry_cycle_%0d: got secs=%0d run=%b warn=%b exp=%b tick=%b, want secs=%0d run=%b warn=%b exp=%b tick=%b",
                 k, secs, running, warn, expired, sec_tick, e_secs, e_run, e_warn, e_exp, e_tick);
      end
    end
    step(10);
    tests_run++;
    if (secs !== 6'd0 || running !== 1'b0 || exp_seen - seen0 != 1) begin
      tests_failed++;
      $display("FAIL expired_hold: got secs=%0d run=%b pulses=%0d, want secs=0 run=0 pulses=1",
               secs, running, exp_seen - seen0);
    end
  endtask

  task automatic test_activity_reload();
    go_idle();
    pulse_start();
    step(8);
    tests_run++;
    if (secs !== 6'd3) begin
      tests_failed++;
      $display("FAIL reload_pre: got secs=%0d, want 3", secs);
    end
    activity = 1'b1;
    step();
    activity = 1'b0;
    tests_run++;
    if (secs !== 6'd5 || running !== 1'b1 || warn !== 1'b0 || sec_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL reload_next: got secs=%0d run=%b warn=%b tick=%b, want 5 1 0 0",
               secs, running, warn, sec_tick);
    end
    step(3);
    tests_run++;
    if (secs !== 6'd5 || sec_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL reload_hold: got secs=%0d tick=%b, want 5 0", secs, sec_tick);
    end
    step();
    tests_run++;
    if (secs !== 6'd4 || sec_tick !== 1'b1) begin
      tests_failed++;
      $display("FAIL reload_first_dec: got secs=%0d tick=%b, want 4 1", secs, sec_tick);
    end
    go_idle();
  endtask

  task automatic test_final_tick_activity();
    int seen0;
    go_idle();
    seen0 = exp_seen;
    pulse_start();
    step(19);
    tests_run++;
    if (secs !== 6'd1 || warn !== 1'b1) begin
      tests_failed++;
      $display("FAIL final_pre: got secs=%0d warn=%b, want 1 1", secs, warn);
    end
    activity = 1'b1;
    step();
    activity = 1'b0;
    tests_run++;
    if (secs !== 6'd5 || running !== 1'b1 || warn !== 1'b0 || expired !== 1'b0 || sec_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL final_collide: got secs=%0d run=%b warn=%b exp=%b tick=%b, want 5 1 0 0 0",
               secs, running, warn, expired, sec_tick);
    end
    step(4);
    tests_run++;
    if (secs !== 6'd4 || exp_seen != seen0) begin
      tests_failed++;
      $display("FAIL final_after: got secs=%0d pulses=%0d, want 4 0", secs, exp_seen - seen0);
    end
    go_idle();
  endtask

  task automatic test_cancel_priority();
    int seen0;
    go_idle();
    seen0 = exp_seen;
    pulse_start();
    step(12);
    tests_run++;
    if (secs !== 6'd2 || warn !== 1'b1) begin
      tests_failed++;
      $display("FAIL cancel_pre: got secs=%0d warn=%b, want 2 1", secs, warn);
    end
    cancel   = 1'b1;
    activity = 1'b1;
    step();
    cancel   = 1'b0;
    activity = 1'b0;
    tests_run++;
    if ({secs, running, warn, expired, sec_tick} !== 10'd0) begin
      tests_failed++;
      $display("FAIL cancel_wins: got secs=%0d run=%b warn=%b exp=%b tick=%b, want all 0",
               secs, running, warn, expired, sec_tick);
    end
    step(25);
    tests_run++;
    if (secs !== 6'd0 || running !== 1'b0 || exp_seen != seen0) begin
      tests_failed++;
      $display("FAIL cancel_idle: got secs=%0d run=%b pulses=%0d, want 0 0 0",
               secs, running, exp_seen - seen0);
    end
    pulse_start();
    tests_run++;
    if (secs !== 6'd5 || running !== 1'b1) begin
      tests_failed++;
      $display("FAIL cancel_restart: got secs=%0d run=%b, want 5 1", secs, running);
    end
    go_idle();
  endtask

  task automatic test_async_reset();
    int seen0;
    go_idle();
    seen0 = exp_seen;
    pulse_start();
    step(8);
    tests_run++;
    if (secs !== 6'd3 || running !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_pre: got secs=%0d run=%b, want 3 1", secs, running);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({secs, running, warn, expired, sec_tick} !== 10'd0) begin
      tests_failed++;
      $display("FAIL areset_immediate: got secs=%0d run=%b warn=%b exp=%b tick=%b, want all 0",
               secs, running, warn, expired, sec_tick);
    end
    step(30);
    rst_n = 1'b1;
    step(3);
    tests_run++;
    if ({secs, running, warn, expired, sec_tick} !== 10'd0 || exp_seen != seen0) begin
      tests_failed++;
      $display("FAIL areset_after: got secs=%0d run=%b pulses=%0d, want 0 0 0",
               secs, running, exp_seen - seen0);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    activity     = 1'b0;
    cancel       = 1'b0;
    test_reset();
    test_full_expiry();
    test_activity_reload();
    test_final_tick_activity();
    test_cancel_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
